// File: rtl/bus_slave_resp_mux_pkg.sv
// Shared definitions for the slave read-response mux: state encoding,
// parameter defaults and index-width helper.
package bus_slave_resp_mux_pkg;

  localparam int unsigned SLV_NUM_DEF = 8;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned TMO_CYC_DEF = 256;

  typedef enum logic [1:0] {
    BSM_IDLE = 2'd0,
    BSM_DATA = 2'd1,
    BSM_DFLT = 2'd2,
    BSM_TMO  = 2'd3
  } bsm_state_e;

  // Counter/index width that never collapses to zero bits.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_slave_resp_mux_if.sv
// Slave-side read-response bus between the address decoder, the slaves and
// the bus master, as seen by the response mux.
interface bus_slave_resp_mux_if
  import bus_slave_resp_mux_pkg::*;
#(
  parameter int unsigned SLV_NUM = SLV_NUM_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
);

  logic                      m_as_;
  logic [SLV_NUM-1:0]        s_cs_;
  logic [SLV_NUM*DATA_W-1:0] s_rd_data;
  logic [SLV_NUM-1:0]        s_rdy;
  logic [DATA_W-1:0]         m_rd_data;
  logic                      m_rdy;
  logic                      m_err;
  logic                      m_cs_multi;

  modport slave (
    input  m_as_,
    input  s_cs_,
    input  s_rd_data,
    input  s_rdy,
    output m_rd_data,
    output m_rdy,
    output m_err,
    output m_cs_multi
  );

  modport master (
    output m_as_,
    output s_cs_,
    output s_rd_data,
    output s_rdy,
    input  m_rd_data,
    input  m_rdy,
    input  m_err,
    input  m_cs_multi
  );

endinterface

// File: rtl/bus_slave_resp_mux_prio_enc.sv
// Active-low chip-select priority encoder: lowest asserted index wins,
// plus "any asserted" and "more than one asserted" flags.
module bus_slave_prio_enc
  import bus_slave_resp_mux_pkg::*;
#(
  parameter  int unsigned SLV_NUM = SLV_NUM_DEF,
  localparam int unsigned IDX_W   = idx_width(SLV_NUM)
) (
  input  logic [SLV_NUM-1:0] cs_,
  output logic [IDX_W-1:0]   idx,
  output logic               any,
  output logic               multi
);

  always_comb begin
    idx   = '0;
    any   = 1'b0;
    multi = 1'b0;
    for (int unsigned i = 0; i < SLV_NUM; i++) begin
      if (!cs_[i]) begin
        if (any) begin
          multi = 1'b1;
        end else begin
          idx = IDX_W'(i);
          any = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bus_slave_resp_mux.sv
// Pipelined slave read-response mux: latches the selected slave in the address
// phase, steers its data/ready in the data phase, adds default-slave and watchdog errors.
module bus_slave_resp_mux
  import bus_slave_resp_mux_pkg::*;
#(
  parameter int unsigned SLV_NUM = SLV_NUM_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TMO_CYC = TMO_CYC_DEF
) (
  input logic                 clk,
  input logic                 reset_,
  bus_slave_resp_mux_if.slave bus
);

  localparam int unsigned      IDX_W    = idx_width(SLV_NUM);
  localparam int unsigned      TMO_W    = idx_width(TMO_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  bsm_state_e        state;
  logic [IDX_W-1:0]  sel_idx;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              cs_multi;

  logic [IDX_W-1:0]  enc_idx;
  logic              enc_any;
  logic              enc_multi;

  logic              sel_rdy;
  logic [DATA_W-1:0] sel_data;
  logic              rdy;
  logic              err;
  logic [DATA_W-1:0] rd_data;
  logic              accept;

  bus_slave_prio_enc #(
    .SLV_NUM (SLV_NUM)
  ) u_prio_enc (
    .cs_   (bus.s_cs_),
    .idx   (enc_idx),
    .any   (enc_any),
    .multi (enc_multi)
  );

  always_comb begin
    sel_rdy  = bus.s_rdy[sel_idx];
    sel_data = bus.s_rd_data[sel_idx*DATA_W +: DATA_W];
  end

  // Data-phase outputs are combinational from the latched index so a
  // zero-wait slave completes one cycle after the address strobe.
  always_comb begin
    rdy     = 1'b0;
    err     = 1'b0;
    rd_data = '0;
    unique case (state)
      BSM_IDLE: ;
      BSM_DATA: begin
        rdy     = sel_rdy;
        rd_data = sel_data;
      end
      BSM_DFLT, BSM_TMO: begin
        rdy = 1'b1;
        err = 1'b1;
      end
      default: ;
    endcase
  end

  assign accept = !bus.m_as_ && ((state == BSM_IDLE) || rdy);

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state    <= BSM_IDLE;
      sel_idx  <= '0;
      tmo_cnt  <= '0;
      cs_multi <= 1'b0;
    end else if (accept) begin
      state   <= enc_any ? BSM_DATA : BSM_DFLT;
      sel_idx <= enc_idx;
      tmo_cnt <= '0;
      if (enc_multi) begin
        cs_multi <= 1'b1;
      end
    end else begin
      unique case (state)
        BSM_IDLE: ;
        BSM_DATA: begin
          // Ready on the final watchdog cycle still counts as a normal completion.
          if (sel_rdy) begin
            state   <= BSM_IDLE;
            tmo_cnt <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            state   <= BSM_TMO;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        BSM_DFLT, BSM_TMO: state <= BSM_IDLE;
        default:           state <= BSM_IDLE;
      endcase
    end
  end

  assign bus.m_rd_data  = rd_data;
  assign bus.m_rdy      = rdy;
  assign bus.m_err      = err;
  assign bus.m_cs_multi = cs_multi;

endmodule

// File: tb/tb_bus_slave_resp_mux.sv
// Directed bench for bus_slave_resp_mux (8 slaves, 32-bit data, 16-cycle watchdog).
module tb_bus_slave_resp_mux;

  localparam int unsigned SLV_NUM = 8;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TMO_CYC = 16;

  logic clk;
  logic reset_;
  int   vectors;
  int   miscompares;

  bus_slave_resp_mux_if #(.SLV_NUM(SLV_NUM), .DATA_W(DATA_W)) bus ();

  bus_slave_resp_mux #(
    .SLV_NUM (SLV_NUM),
    .DATA_W  (DATA_W),
    .TMO_CYC (TMO_CYC)
  ) dut (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after the rising edge; outputs are checked on the falling edge.
  task automatic next_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_        = 1'b0;
    bus.m_as_     = 1'b1;
    bus.s_cs_     = 8'hFF;
    bus.s_rdy     = 8'hFF;
    for (int i = 0; i < 8; i++) bus.s_rd_data[i*32 +: 32] = 32'hC0DE_0000 | i;
    repeat (2) next_drive();
    @(negedge clk);
    vectors++;
    if (bus.m_rdy !== 1'b0) begin miscompares++; $display("FAIL reset_rdy got %b want 0", bus.m_rdy); end
    vectors++;
    if (bus.m_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", bus.m_err); end
    vectors++;
    if (bus.m_rd_data !== 32'h0) begin miscompares++; $display("FAIL reset_data got %h want 0", bus.m_rd_data); end
    vectors++;
    if (bus.m_cs_multi !== 1'b0) begin miscompares++; $display("FAIL reset_multi got %b want 0", bus.m_cs_multi); end
    next_drive();
    reset_ = 1'b1;
  endtask

  task automatic test_zero_wait();
    next_drive();
    bus.m_as_ = 1'b0;
    bus.s_cs_ = 8'hFB;
    bus.s_rdy = 8'h04;
    bus.s_rd_data[2*32 +: 32] = 32'hDEADBEEF;
    @(negedge clk);
    vectors++;
    if (bus.m_rdy !== 1'b0) begin miscompares++; $display("FAIL zw_idle_rdy got %b want 0", bus.m_rdy); end
    next_drive();
    bus.m_as_ = 1'b1;
    bus.s_cs_ = 8'hFF;
    @(negedge clk);
    vectors++;
    if (bus.m_rdy !== 1'b1 || bus.m_err !== 1'b0 || bus.m_rd_data !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL zw_done got rdy=%b err=%b data=%h want 1 0 deadbeef", bus.m_rdy, bus.m_err, bus.m_rd_data);
    end
    next_drive();
    @(negedge clk);
    vectors++;
    if (bus.m_rdy !== 1'b0 || bus.m_rd_data !== 32'h0) begin
      miscompares++;
      $display("FAIL zw_back_idle got rdy=%b data=%h want 0 0", bus.m_rdy, bus.m_rd_data);
    end
  endtask

  task automatic test_back_to_back();
    next_drive();
    bus.s_rdy = 8'hFF;
    bus.m_as_ = 1'b0;
    bus.s_cs_ = 8'hFD;
    next_drive();
    bus.m_as_ = 1'b0;
    bus.s_cs_ = 8'hDF;
    @(negedge clk);
    vectors++;
    if (bus.m_rdy !== 1'b1 || bus.m_err !== 1'b0 || bus.m_rd_data !== 32'hC0DE0001) begin
      miscompares++;
      $display("FAIL b2b_first got rdy=%b err=%b data=%h want 1 0 c0de0001", bus.m_rdy, bus.m_err, bus.m_rd_data);
    end
    next_drive();
    bus.m_as_ = 1'b1;
    bus.s_cs_ = 8'hFF;
    @(negedge clk);
    vectors++;
    if (bus.m_rdy !== 1'b1 || bus.m_err !== 1'b0 || bus.m_rd_data !== 32'hC0DE0005) begin
      miscompares++;
      $display("FAIL b2b_second got rdy=%b err=%b data=%h want 1 0 c0de0005", bus.m_rdy, bus.m_err, bus.m_rd_data);
    end
    next_drive();
    @(negedge clk);
    vectors++;
    if (bus.m_rdy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle got rdy=%b want 0", bus.m_rdy); end
  endtask

  task automatic test_wait_states();
    logic       as_pat[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] cs_pat[4] = '{8'hFE, 8'hFF, 8'hFF, 8'hBF};
    next_drive();
    bus.s_rdy = 8'hF7;
    bus.m_as_ = 1'b0;
    bus.s_cs_ = 8'hF7;
    for (int k = 0; k < 4; k++) begin
      next_drive();
      bus.m_as_ = as_pat[k];
      bus.s_cs_ = cs_pat[k];
      @(negedge clk);
      vectors++;
      if (bus.m_rdy !== 1'b0 || bus.m_rd_data !== 32'hC0DE0003) begin
        miscompares++;
        $display("FAIL wait_cycle%0d got rdy=%b data=%h want 0 c0de0003", k + 1, bus.m_rdy, bus.m_rd_data);
      end
    end
    next_drive();
    bus.m_as_ = 1'b1;
    bus.s_cs_ = 8'hFF;
    bus.s_rdy = 8'hFF;
    @(negedge clk);
    vectors++;
    if (bus.m_rdy !== 1'b1 || bus.m_err !== 1'b0 || bus.m_rd_data !== 32'hC0DE0003) begin
      miscompares++;
      $display("FAIL wait_done got rdy=%b err=%b data=%h want 1 0 c0de0003", bus.m_rdy, bus.m_err, bus.m_rd_data);
    end
    next_drive();
    @(negedge clk);
    vectors++;
    if (bus.m_rdy !== 1'b0) begin miscompares++; $display("FAIL wait_idle got rdy=%b want 0", bus.m_rdy); end
  endtask

  task automatic test_unmapped();
    next_drive();
    bus.m_as_ = 1'b0;
    bus.s_cs_ = 8'hFF;
    next_drive();
    bus.m_as_ = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.m_rdy !== 1'b1 || bus.m_err !== 1'b1 || bus.m_rd_data !== 32'h0) begin
      miscompares++;
      $display("FAIL dflt_resp got rdy=%b err=%b data=%h want 1 1 0", bus.m_rdy, bus.m_err, bus.m_rd_data);
    end
    next_drive();
    @(negedge clk);
    vectors++;
    if (bus.m_rdy !== 1'b0 || bus.m_err !== 1'b0) begin
      miscompares++;
      $display("FAIL dflt_idle got rdy=%b err=%b want 0 0", bus.m_rdy, bus.m_err);
    end
  endtask

  task automatic test_timeout();
    // Slave 0 never ready: 16 silent data cycles, error on cycle 17.
    next_drive();
    bus.s_rdy = 8'hFE;
    bus.m_as_ = 1'b0;
    bus.s_cs_ = 8'hFE;
    for (int k = 1; k <= 16; k++) begin
      next_drive();
      bus.m_as_ = 1'b1;
      bus.s_cs_ = 8'hFF;
      @(negedge clk);
      vectors++;
      if (bus.m_rdy !== 1'b0) begin miscompares++; $display("FAIL tmo_wait%0d got rdy=%b want 0", k, bus.m_rdy); end
    end
    next_drive();
    bus.s_rdy = 8'hFF;
    @(negedge clk);
    vectors++;
    if (bus.m_rdy !== 1'b1 || bus.m_err !== 1'b1 || bus.m_rd_data !== 32'h0) begin
      miscompares++;
      $display("FAIL tmo_resp got rdy=%b err=%b data=%h want 1 1 0", bus.m_rdy, bus.m_err, bus.m_rd_data);
    end
    next_drive();
    @(negedge clk);
    vectors++;
    if (bus.m_rdy !== 1'b0) begin miscompares++; $display("FAIL tmo_idle got rdy=%b want 0", bus.m_rdy); end

    // Ready arriving on the 16th data cycle completes normally.
    next_drive();
    bus.s_rdy = 8'hFE;
    bus.m_as_ = 1'b0;
    bus.s_cs_ = 8'hFE;
    for (int k = 1; k <= 15; k++) begin
      next_drive();
      bus.m_as_ = 1'b1;
      bus.s_cs_ = 8'hFF;
      @(negedge clk);
      vectors++;
      if (bus.m_rdy !== 1'b0) begin miscompares++; $display("FAIL edge_wait%0d got rdy=%b want 0", k, bus.m_rdy); end
    end
    next_drive();
    bus.s_rdy = 8'hFF;
    @(negedge clk);
    vectors++;
    if (bus.m_rdy !== 1'b1 || bus.m_err !== 1'b0 || bus.m_rd_data !== 32'hC0DE0000) begin
      miscompares++;
      $display("FAIL edge_done got rdy=%b err=%b data=%h want 1 0 c0de0000", bus.m_rdy, bus.m_err, bus.m_rd_data);
    end
    next_drive();
    @(negedge clk);
    vectors++;
    if (bus.m_rdy !== 1'b0 || bus.m_err !== 1'b0) begin
      miscompares++;
      $display("FAIL edge_idle got rdy=%b err=%b want 0 0", bus.m_rdy, bus.m_err);
    end
  endtask

  task automatic test_multi_reset();
    next_drive();
    bus.s_rdy = 8'h00;
    bus.m_as_ = 1'b0;
    bus.s_cs_ = 8'hF5;
    next_drive();
    bus.m_as_ = 1'b1;
    bus.s_cs_ = 8'hFF;
    @(negedge clk);
    vectors++;
    if (bus.m_rdy !== 1'b0 || bus.m_rd_data !== 32'hC0DE0001 || bus.m_cs_multi !== 1'b1) begin
      miscompares++;
      $display("FAIL multi_sel got rdy=%b data=%h multi=%b want 0 c0de0001 1", bus.m_rdy, bus.m_rd_data, bus.m_cs_multi);
    end
    next_drive();
    bus.s_rdy = 8'hFF;
    reset_    = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.m_rdy !== 1'b0 || bus.m_err !== 1'b0 || bus.m_rd_data !== 32'h0 || bus.m_cs_multi !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset got rdy=%b err=%b data=%h multi=%b want 0 0 0 0",
               bus.m_rdy, bus.m_err, bus.m_rd_data, bus.m_cs_multi);
    end
    next_drive();
    reset_ = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.m_rdy !== 1'b0 || bus.m_cs_multi !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset got rdy=%b multi=%b want 0 0", bus.m_rdy, bus.m_cs_multi);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_zero_wait();
    test_back_to_back();
    test_wait_states();
    test_unmapped();
    test_timeout();
    test_multi_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
